// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_t;

    localparam int unsigned DEFAULT_N = 32;

    // Number of stream bytes that make up one instruction word of width n.
    function automatic int unsigned bytes_per_word(input int unsigned n);
        return n / 8;
    endfunction

    localparam int unsigned BYTES_PER_WORD = bytes_per_word(DEFAULT_N);

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects stream bytes into a little-endian word (first byte is the LSB).
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_byte_en,
    input  logic [7:0]   i_byte,
    output logic [N-1:0] o_word,
    output logic         o_word_full
);

    localparam int unsigned BPW   = bytes_per_word(N);
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [N-1:0]     r_word;
    logic [IDX_W-1:0] r_byte_idx;
    logic             w_last;

    assign w_last = (r_byte_idx == LAST_IDX);

    // o_word already includes the byte being accepted this cycle, so the
    // completed word is available on the same edge that takes its last byte.
    always_comb begin
        o_word = r_word;
        o_word[{r_byte_idx, 3'b000} +: 8] = i_byte;
        o_word_full = i_byte_en && w_last;
    end

    // Partial-word register and byte position; position wraps after the last byte.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_word     <= '0;
            r_byte_idx <= '0;
        end else if (i_byte_en) begin
            r_word     <= o_word;
            r_byte_idx <= w_last ? '0 : r_byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, holding the CPU in reset meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N-1:0]      wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [N-1:0]      r_wr_data;
    logic              r_cpu_reset;
    logic              r_error;

    logic              w_count_ok;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_xfer;
    logic              w_last_word;
    logic [N-1:0]      w_word;
    logic              w_word_full;

    assign w_count_ok  = (word_count != '0) && (word_count <= DEPTH);
    assign w_start_ok  = (r_state == IDLE) && start && w_count_ok;
    assign w_start_bad = (r_state == IDLE) && start && !w_count_ok;
    assign w_xfer      = byte_valid && byte_ready;
    assign w_last_word = ({1'b0, r_word_idx} == (r_count - 1'b1));

    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cpu_reset = r_cpu_reset;
    assign error     = r_error;

    word_assembler #(
        .N (N)
    ) u_asm (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clear     (w_start_ok),
        .i_byte_en   (w_xfer),
        .i_byte      (byte_in),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and per-state handshake/strobe outputs.
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        wr_en        = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_start_ok) w_state_next = RECV;
            end
            RECV: begin
                byte_ready = 1'b1;
                if (w_word_full) w_state_next = WRITE;
            end
            WRITE: begin
                wr_en        = 1'b1;
                w_state_next = w_last_word ? DONE : RECV;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Session bookkeeping, write-port registers, CPU reset hold and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_word_idx  <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cpu_reset <= 1'b1;
            r_error     <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_count     <= word_count;
                r_word_idx  <= '0;
                r_cpu_reset <= 1'b1;
                r_error     <= 1'b0;
            end
            if (w_start_bad) r_error <= 1'b1;
            // Captured on the edge that takes the last byte, so the registers are
            // valid throughout the following WRITE cycle and hold afterwards.
            if (w_word_full) begin
                r_wr_addr <= r_word_idx;
                r_wr_data <= w_word;
            end
            if (r_state == WRITE && !w_last_word) r_word_idx <= r_word_idx + 1'b1;
            if (r_state == DONE) r_cpu_reset <= 1'b0;
        end
    end

endmodule
